// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V main control unit and alu_control.
// Holds opcode values, alu_op codes, state encoding and datapath mux selects.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // alu_op is the contract with alu_control: FUNCT asks it to decode funct3.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC_R   = 4'd7;
  localparam logic [3:0] S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_ALU_WB   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath strobes, mux selects and alu_op from the state register.
module main_control_fsm
  import ctrl_pkg::*;
#(
  parameter bit RESET_TRAP_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       halted,
  output logic [3:0] dbg_state
);

  logic [3:0] r_state;
  logic [3:0] w_next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = S_FETCH;
      S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(opcode))       w_next_state = S_MEM_ADDR;
        else if (opcode == OP_R)      w_next_state = S_EXEC_R;
        else if (opcode == OP_I)      w_next_state = S_EXEC_I;
        else if (opcode == OP_BRANCH) w_next_state = S_BRANCH;
        else                          w_next_state = S_TRAP;
      end
      S_MEM_ADDR: w_next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) w_next_state = S_MEM_WB;
      S_MEM_WB:   w_next_state = S_FETCH;
      S_MEM_WR:   if (mem_ready) w_next_state = S_FETCH;
      S_EXEC_R:   w_next_state = S_ALU_WB;
      S_EXEC_I:   w_next_state = S_ALU_WB;
      S_ALU_WB:   w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_TRAP:     w_next_state = RESET_TRAP_STICKY ? S_TRAP : S_FETCH;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Only FETCH and BRANCH look at inputs; every other output is pure state decode.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = RES_MDR;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        if (funct3 == F3_BNE)      pc_write = ~zero;
        else if (funct3 == F3_BEQ) pc_write = zero;
      end
      S_TRAP:  halted = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = r_state;

endmodule
